// File: rtl/dmem_pkg.sv
// Shared definitions for the block-granular data memory: FSM state
// encoding, block geometry and the access-latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam int unsigned BYTES_PER_BLOCK = 4;
  localparam int unsigned BLOCK_W         = 8 * BYTES_PER_BLOCK;
  localparam int unsigned MAX_LATENCY     = 15;
  localparam int unsigned CNT_W           = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/dmem_array.sv
// Storage for data_mem_block: 2**ADDR_W blocks of BLOCK_W bits with
// synchronous write and registered read. Reset clears the read register
// and suppresses any write in that cycle.
// Optional macro DMEM_CLEAR_ON_RESET_EN: reset also zeroes every block.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Registered read port; cleared by reset, untouched by writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  // Write port; a reset cycle zeroes the whole array in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Write port; contents survive reset, but no write lands during reset.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[addr] <= wdata;
    end
  end
`endif

endmodule

// File: rtl/data_mem_block.sv
// Block data memory answering the data cache's memory port. A request is
// accepted in IDLE, served after LATENCY edges in ACCESS, then one DONE
// cycle with mem_busywait low lets the cache take the result.
// Optional macro DMEM_CLEAR_ON_RESET_EN: reset also clears the storage.
module data_mem_block
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned LATENCY = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               mem_busywait
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   counter;
  logic [ADDR_W-1:0]  lat_addr;
  logic [BLOCK_W-1:0] lat_data;
  logic               lat_write;
  logic               request;
  logic               commit;

  assign request = mem_read | mem_write;
  assign commit  = (state == ACCESS) && (counter == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latency counter: loaded on acceptance, counts down to the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (state == IDLE && request) begin
      counter <= CNT_INIT;
    end else if (state == ACCESS && counter != '0) begin
      counter <= counter - 1'b1;
    end
  end

  // Request capture at acceptance; write wins if both strobes are high.
  always_ff @(posedge clk) begin
    if (state == IDLE && request) begin
      lat_addr  <= mem_address;
      lat_data  <= mem_writedata;
      lat_write <= mem_write;
    end
  end

  // Next-state and busywait decode.
  always_comb begin
    next_state   = state;
    mem_busywait = 1'b0;
    case (state)
      IDLE: begin
        mem_busywait = request;
        if (request) next_state = ACCESS;
      end
      ACCESS: begin
        mem_busywait = 1'b1;
        if (counter == '0) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit && lat_write),
    .re    (commit && !lat_write),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (mem_readdata)
  );

endmodule
